// File: rtl/puf_run_scheduler.sv
// puf_run_scheduler
//   Repeats engine evaluations of one loaded challenge pair. The first Up/Down
//   responses are captured, and every later run ORs its difference from run 0
//   into per-bit instability masks.
//
// Ports
//   clk, reset (async, active low)
//   startReq/runCount/startAck : host batch request, run count (0 means 1), accept pulse
//   busy/done/timeoutErr       : batch in progress, end-of-batch pulse, sticky watchdog flag
//   exStart/exDone             : engine handshake
//   responseUp/responseDown    : engine responses, valid while exDone is high
//   firstUp/firstDown          : run-0 responses
//   flipUp/flipDown            : instability masks
//   runsCompleted              : runs captured in the current or last batch
module puf_run_scheduler #(
    parameter int RUN_COUNT_WIDTH = 16,
    parameter int SETTLE_CYCLES   = 4,
    parameter int TIMEOUT_WIDTH   = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startReq,
    input  logic [RUN_COUNT_WIDTH-1:0] runCount,
    output logic                       startAck,
    output logic                       busy,
    output logic                       done,
    output logic                       timeoutErr,
    output logic                       exStart,
    input  logic                       exDone,
    input  logic [127:0]               responseUp,
    input  logic [127:0]               responseDown,
    output logic [127:0]               firstUp,
    output logic [127:0]               firstDown,
    output logic [127:0]               flipUp,
    output logic [127:0]               flipDown,
    output logic [RUN_COUNT_WIDTH-1:0] runsCompleted
);

    localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        WAIT_CLEAR,
        SETTLE,
        FINISH
    } state_t;

    state_t                     state;
    state_t                     stateNext;
    logic [RUN_COUNT_WIDTH-1:0] target;
    logic [TIMEOUT_WIDTH-1:0]   wdog;
    logic [SETTLE_W-1:0]        settleCnt;

    logic accept;
    logic launch;
    logic capture;
    logic expire;
    logic loadSettle;
    logic wdogHit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        loadSettle = 1'b0;
        wdogHit    = (wdog == '1);
        case (state)
            IDLE: begin
                if (startReq) begin
                    accept    = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                launch    = 1'b1;
                stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A response already present on entry counts as progress and
                // wins over a simultaneous watchdog expiry.
                if (exDone) begin
                    capture   = 1'b1;
                    stateNext = WAIT_CLEAR;
                end else if (wdogHit) begin
                    expire    = 1'b1;
                    stateNext = FINISH;
                end
            end
            WAIT_CLEAR: begin
                if (!exDone) begin
                    if (runsCompleted == target) begin
                        stateNext = FINISH;
                    end else if (SETTLE_CYCLES == 0) begin
                        stateNext = START;
                    end else begin
                        loadSettle = 1'b1;
                        stateNext  = SETTLE;
                    end
                end else if (wdogHit) begin
                    expire    = 1'b1;
                    stateNext = FINISH;
                end
            end
            SETTLE: begin
                if (settleCnt <= SETTLE_W'(1)) begin
                    stateNext = START;
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startAck      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeoutErr    <= 1'b0;
            exStart       <= 1'b0;
            firstUp       <= '0;
            firstDown     <= '0;
            flipUp        <= '0;
            flipDown      <= '0;
            runsCompleted <= '0;
            target        <= '0;
            wdog          <= '0;
            settleCnt     <= '0;
        end else begin
            startAck <= accept;
            done     <= (state == FINISH);

            if (accept) begin
                target        <= (runCount == '0) ? RUN_COUNT_WIDTH'(1) : runCount;
                runsCompleted <= '0;
                flipUp        <= '0;
                flipDown      <= '0;
                timeoutErr    <= 1'b0;
                busy          <= 1'b1;
            end

            if (state == FINISH) begin
                busy <= 1'b0;
            end

            if (launch) begin
                exStart <= 1'b1;
                wdog    <= '0;
            end

            if (capture) begin
                if (runsCompleted == '0) begin
                    firstUp   <= responseUp;
                    firstDown <= responseDown;
                end else begin
                    flipUp   <= flipUp | (responseUp ^ firstUp);
                    flipDown <= flipDown | (responseDown ^ firstDown);
                end
                runsCompleted <= runsCompleted + RUN_COUNT_WIDTH'(1);
                exStart       <= 1'b0;
                wdog          <= '0;
            end else if (expire) begin
                timeoutErr <= 1'b1;
                exStart    <= 1'b0;
            end else if (state == WAIT_DONE || state == WAIT_CLEAR) begin
                wdog <= wdog + TIMEOUT_WIDTH'(1);
            end

            if (loadSettle) begin
                settleCnt <= SETTLE_W'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                settleCnt <= settleCnt - SETTLE_W'(1);
            end
        end
    end

endmodule

// File: doc/puf_run_scheduler.md
# puf_run_scheduler

Sequences the PUF serial transmit/receive engine through repeated evaluations of one loaded challenge pair, for reliability characterisation. It sits between the host-facing FSM and the engine's ExStart/ExDone handshake. It captures the first Up/Down responses and accumulates a per-bit instability mask: a bit is set if any later run differed from run 0. The host FSM writes these results to output memory.

## Interface

Parameters:
- RUN_COUNT_WIDTH, 16: width of the requested run count and of the completed-run counter.
- SETTLE_CYCLES, 4: idle cycles inserted between consecutive engine runs. 0 is legal.
- TIMEOUT_WIDTH, 24: width of the watchdog counter. A stalled engine is abandoned after 2^TIMEOUT_WIDTH − 1 cycles without progress.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- startReq, in, 1: host request to begin a characterisation batch. Level, held until startAck.
- runCount, in, RUN_COUNT_WIDTH: number of engine runs; sampled at acceptance. 0 is treated as 1.
- startAck, out, 1: one-cycle pulse confirming acceptance.
- busy, out, 1: high from acceptance until the done pulse, inclusive of the done cycle's predecessor.
- done, out, 1: one-cycle pulse when the batch ends, normally or by timeout.
- timeoutErr, out, 1: sticky; set on watchdog expiry; cleared at the next acceptance.
- exStart, out, 1: engine start request.
- exDone, in, 1: engine completion level. Responses are valid while high.
- responseUp, in, 128: engine upper-chain response.
- responseDown, in, 128: engine lower-chain response.
- firstUp, out, 128: run-0 upper response.
- firstDown, out, 128: run-0 lower response.
- flipUp, out, 128: upper instability mask.
- flipDown, out, 128: lower instability mask.
- runsCompleted, out, RUN_COUNT_WIDTH: engine runs captured in the current or last batch.

## Operation

- States: IDLE, START, WAIT_DONE, WAIT_CLEAR, SETTLE, FINISH.
- IDLE:
  - When startReq=1, latch the target as max(runCount, 1).
  - Clear runsCompleted, flipUp/flipDown and timeoutErr.
  - Pulse startAck, set busy, go to START.
- START: assert exStart, clear the watchdog, go to WAIT_DONE.
- WAIT_DONE: on exDone=1:
  - If runsCompleted==0: load firstUp/firstDown from the responses.
  - Otherwise: flipUp |= responseUp ^ firstUp; flipDown likewise.
  - Increment runsCompleted, drop exStart, clear the watchdog, go to WAIT_CLEAR.
- WAIT_CLEAR: wait for exDone=0, i.e. the engine has returned to idle.
  - If runsCompleted == target: go to FINISH.
  - Else if SETTLE_CYCLES==0: go to START.
  - Else: load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE: decrement the counter each cycle; when it reaches 1, go to START.
- FINISH: pulse done, drop busy, go to IDLE.
- Watchdog:
  - Counts every cycle spent in WAIT_DONE or WAIT_CLEAR.
  - At all-ones: set timeoutErr, drop exStart, go to FINISH.
  - Captured data and runsCompleted keep the values they had at expiry.
- Results (firstUp/firstDown, flipUp/flipDown, runsCompleted) hold after done until the next acceptance. They are readable in IDLE.
- startReq is ignored outside IDLE.
- exDone arriving outside WAIT_DONE is ignored.
- runsCompleted saturates by construction because target ≤ 2^RUN_COUNT_WIDTH − 1.

## Timing

- Reset (async assert, sync release): state IDLE; every output is 0, including all 128-bit buses, runsCompleted, busy, done, startAck and timeoutErr.
- Startup latency: startReq sampled high at edge t gives startAck=1 and busy=1 in cycle t+1, and exStart=1 from t+2.
- exStart is registered and rises one cycle after entering START.
- Capture: with exDone sampled high at edge e, the new firstUp/flipUp and runsCompleted are visible from e+1, and exStart is low from e+1.
- Run-to-run gap: if exDone falls at edge f, the next exStart rises at f+2+SETTLE_CYCLES.
- Completion: done pulses one cycle after the final WAIT_CLEAR exit; busy falls in the same cycle done is high.
- If reset asserts mid-batch: exStart drops immediately (asynchronously) and all results clear. No partial batch resumes.
- If exDone is already high at entry to WAIT_DONE (a stale level), it is captured. The engine must deassert ExDone before re-arming; WAIT_CLEAR enforces this.

## Test plan

- runCount=1, engine returns Up=0xA5…A5, Down=0x3C…3C → firstUp/firstDown equal those values, flips=0, runsCompleted=1, a single exStart pulse, done pulses once, timeoutErr=0.
- runCount=4, Up responses A, A, A^bit7, A^bit100 → flipUp has exactly bits 7 and 100 set, flipDown=0, runsCompleted=4, four exStart rises each separated by SETTLE_CYCLES+2 cycles after exDone falls.
- runCount=0 → behaves as 1 run: runsCompleted=1, done pulses.
- Engine never raises exDone, with TIMEOUT_WIDTH=4 → after 15 cycles in WAIT_DONE, timeoutErr=1, exStart=0, done pulses, runsCompleted=0. The next startReq clears timeoutErr.
- Reset asserted in cycle 2 of run 2 of 3 → exStart=0 and all outputs 0 immediately. After release with startReq=0 the block stays in IDLE.
- startReq held high across a whole batch → a second batch starts immediately after done, and startAck pulses once per batch.
